// File: rtl/dmem_axi_bridge.sv
// Data-side AXI4 master bridge between mem_stage and the data bus.
// Handles one single-beat transaction at a time: a load (AR/R) or a posted store (AW/W/B).
module dmem_axi_bridge #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned AXI_ID = 0
) (
  input  logic                clock,
  input  logic                reset,
  // core load side
  input  logic                rvalid,
  input  logic [ADDR_W-1:0]   raddr,
  input  logic [1:0]          rsize,
  output logic                r_ready,
  output logic [DATA_W-1:0]   data_read,
  output logic [1:0]          resp,
  // core store side
  input  logic                wvalid,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wmask,
  output logic                axi_w_isbusy,
  // AXI AR
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [2:0]          ar_size,
  output logic [7:0]          ar_len,
  output logic [1:0]          ar_burst,
  output logic [3:0]          ar_id,
  // AXI R
  input  logic                r_valid_i,
  output logic                r_ready_o,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_last,
  input  logic [3:0]          r_id,
  // AXI AW
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [2:0]          aw_size,
  output logic [7:0]          aw_len,
  output logic [1:0]          aw_burst,
  output logic [3:0]          aw_id,
  // AXI W
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  // AXI B
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp,
  input  logic [3:0]          b_id
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdAr,
    StRdR,
    StRdDone,
    StWrReq,
    StWrB
  } state_e;

  state_e              state_q, state_d;
  logic                ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [2:0]          ar_size_q, ar_size_d;
  logic                r_ready_o_q, r_ready_o_d;
  logic                ld_done_q, ld_done_d;
  logic [DATA_W-1:0]   data_read_q, data_read_d;
  logic [1:0]          resp_q, resp_d;
  logic                aw_valid_q, aw_valid_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [2:0]          aw_size_q, aw_size_d;
  logic                w_valid_q, w_valid_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [StrbW-1:0]    w_strb_q, w_strb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                b_ready_q, b_ready_d;
  logic                busy_q, busy_d;

  logic aw_hs, w_hs;

  // Ignored slave fields; the bridge only ever has one beat in flight.
  logic unused_inputs;
  assign unused_inputs = ^{r_last, r_id, b_resp, b_id};

  // Store size follows the number of enabled byte lanes; irregular masks use a full beat.
  function automatic logic [2:0] size_from_mask(input logic [StrbW-1:0] m);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(StrbW); i++) begin
      cnt += 32'(m[i]);
    end
    case (cnt)
      8:       size_from_mask = 3'd3;
      4:       size_from_mask = 3'd2;
      2:       size_from_mask = 3'd1;
      1:       size_from_mask = 3'd0;
      default: size_from_mask = 3'd3;
    endcase
  endfunction

  assign aw_hs = aw_valid_q & aw_ready;
  assign w_hs  = w_valid_q & w_ready;

  always_comb begin
    state_d     = state_q;
    ar_valid_d  = ar_valid_q;
    ar_addr_d   = ar_addr_q;
    ar_size_d   = ar_size_q;
    r_ready_o_d = r_ready_o_q;
    ld_done_d   = 1'b0;
    data_read_d = data_read_q;
    resp_d      = resp_q;
    aw_valid_d  = aw_valid_q;
    aw_addr_d   = aw_addr_q;
    aw_size_d   = aw_size_q;
    w_valid_d   = w_valid_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    b_ready_d   = b_ready_q;
    busy_d      = busy_q;

    case (state_q)
      StIdle: begin
        // A read wins if both requests show up together.
        if (rvalid) begin
          ar_addr_d  = raddr;
          ar_size_d  = {1'b0, rsize};
          ar_valid_d = 1'b1;
          state_d    = StRdAr;
        end else if (wvalid) begin
          aw_addr_d  = waddr;
          aw_size_d  = size_from_mask(wmask);
          w_data_d   = wdata;
          w_strb_d   = wmask;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          busy_d     = 1'b1;
          state_d    = StWrReq;
        end
      end
      StRdAr: begin
        if (ar_ready) begin
          ar_valid_d  = 1'b0;
          r_ready_o_d = 1'b1;
          state_d     = StRdR;
        end
      end
      StRdR: begin
        if (r_valid_i) begin
          r_ready_o_d = 1'b0;
          data_read_d = r_data;
          resp_d      = r_resp;
          // A request withdrawn before the beat lands is a flush: no strobe.
          ld_done_d   = rvalid;
          state_d     = StRdDone;
        end
      end
      StRdDone: begin
        state_d = StIdle;
      end
      StWrReq: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          b_ready_d = 1'b1;
          state_d   = StWrB;
        end
      end
      StWrB: begin
        if (b_valid) begin
          b_ready_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      ar_size_q   <= '0;
      r_ready_o_q <= 1'b0;
      ld_done_q   <= 1'b0;
      data_read_q <= '0;
      resp_q      <= '0;
      aw_valid_q  <= 1'b0;
      aw_addr_q   <= '0;
      aw_size_q   <= '0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ar_valid_q  <= ar_valid_d;
      ar_addr_q   <= ar_addr_d;
      ar_size_q   <= ar_size_d;
      r_ready_o_q <= r_ready_o_d;
      ld_done_q   <= ld_done_d;
      data_read_q <= data_read_d;
      resp_q      <= resp_d;
      aw_valid_q  <= aw_valid_d;
      aw_addr_q   <= aw_addr_d;
      aw_size_q   <= aw_size_d;
      w_valid_q   <= w_valid_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      b_ready_q   <= b_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign r_ready      = ld_done_q;
  assign data_read    = data_read_q;
  assign resp         = resp_q;
  assign axi_w_isbusy = busy_q;

  assign ar_valid = ar_valid_q;
  assign ar_addr  = ar_addr_q;
  assign ar_size  = ar_size_q;
  assign ar_len   = 8'd0;
  assign ar_burst = 2'b01;
  assign ar_id    = 4'(AXI_ID);

  assign r_ready_o = r_ready_o_q;

  assign aw_valid = aw_valid_q;
  assign aw_addr  = aw_addr_q;
  assign aw_size  = aw_size_q;
  assign aw_len   = 8'd0;
  assign aw_burst = 2'b01;
  assign aw_id    = 4'(AXI_ID);

  assign w_valid = w_valid_q;
  assign w_data  = w_data_q;
  assign w_strb  = w_strb_q;
  assign w_last  = w_valid_q;

  assign b_ready = b_ready_q;

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Scoreboard bench for dmem_axi_bridge: driver issues loads/stores, a negedge process
// plays the AXI slave and checks every handshake and load strobe against queued expectations.
module tb_dmem_axi_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        rvalid;
  logic [63:0] raddr;
  logic [1:0]  rsize;
  logic        r_ready;
  logic [63:0] data_read;
  logic [1:0]  resp;
  logic        wvalid;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        axi_w_isbusy;
  logic        ar_valid, ar_ready;
  logic [63:0] ar_addr;
  logic [2:0]  ar_size;
  logic [7:0]  ar_len;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_id;
  logic        r_valid_i, r_ready_o;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;
  logic        aw_valid, aw_ready;
  logic [63:0] aw_addr;
  logic [2:0]  aw_size;
  logic [7:0]  aw_len;
  logic [1:0]  aw_burst;
  logic [3:0]  aw_id;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  always #5 clock = ~clock;

  dmem_axi_bridge #(
    .ADDR_W(64),
    .DATA_W(64),
    .AXI_ID(0)
  ) dut (
    .clock(clock), .reset(reset),
    .rvalid(rvalid), .raddr(raddr), .rsize(rsize),
    .r_ready(r_ready), .data_read(data_read), .resp(resp),
    .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .axi_w_isbusy(axi_w_isbusy),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
    .ar_len(ar_len), .ar_burst(ar_burst), .ar_id(ar_id),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_size(aw_size),
    .aw_len(aw_len), .aw_burst(aw_burst), .aw_id(aw_id),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id)
  );

  typedef struct {logic [63:0] addr; logic [2:0] size;} addr_t;
  typedef struct {logic [63:0] data; logic [7:0] strb;} wbeat_t;
  typedef struct {logic [63:0] data; logic [1:0] resp;} rbeat_t;

  addr_t  exp_ar_q[$];
  addr_t  exp_aw_q[$];
  wbeat_t exp_w_q[$];
  rbeat_t slv_r_q[$];
  rbeat_t exp_ld_q[$];

  int total = 0;
  int bad = 0;
  int ld_strobes = 0;
  int exp_strobes = 0;

  // slave wait knobs, loaded by the driver per transaction
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // ---------------- slave + monitor ----------------
  bit r_pend = 0, aw_got = 0, w_got = 0, exp_busy = 0;
  bit hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0, store_acc = 0;
  bit prev_arv = 0, prev_awv = 0, prev_wv = 0;
  logic [63:0] prev_ar_addr, prev_aw_addr;

  initial begin
    ar_ready = 0; r_valid_i = 0; r_data = 0; r_resp = 0; r_last = 1; r_id = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0; b_id = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ar_ready = 0; r_valid_i = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        r_pend = 0; aw_got = 0; w_got = 0; exp_busy = 0; store_acc = 0;
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
        prev_arv = 0; prev_awv = 0; prev_wv = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
        slv_r_q.delete(); exp_ld_q.delete();
      end else begin
        // effects of the handshakes at the posedge just passed
        if (hs_r) begin
          r_valid_i = 0;
          r_pend = 0;
          if (slv_r_q.size() > 0) void'(slv_r_q.pop_front());
        end
        if (hs_ar) r_pend = 1;
        if (hs_aw) aw_got = 1;
        if (hs_w) w_got = 1;
        if (hs_b) begin
          b_valid = 0; aw_got = 0; w_got = 0; exp_busy = 0;
        end
        if (store_acc) exp_busy = 1;
        if (prev_arv && !hs_ar) begin
          check("ar_valid_hold", ar_valid, 1);
          check("ar_addr_hold", ar_addr, prev_ar_addr);
        end
        if (prev_awv && !hs_aw) begin
          check("aw_valid_hold", aw_valid, 1);
          check("aw_addr_hold", aw_addr, prev_aw_addr);
        end
        if (prev_wv && !hs_w) check("w_valid_hold", w_valid, 1);

        // slave drive for the coming posedge
        ar_ready = 0;
        if (ar_valid) begin
          if (ar_cnt == 0) ar_ready = 1;
          else ar_cnt--;
        end
        if (r_pend && !r_valid_i && slv_r_q.size() > 0) begin
          if (r_cnt == 0) begin
            r_valid_i = 1;
            r_data = slv_r_q[0].data;
            r_resp = slv_r_q[0].resp;
          end else r_cnt--;
        end
        aw_ready = 0;
        if (aw_valid) begin
          if (aw_cnt == 0) aw_ready = 1;
          else aw_cnt--;
        end
        w_ready = 0;
        if (w_valid) begin
          if (w_cnt == 0) w_ready = 1;
          else w_cnt--;
        end
        if (aw_got && w_got && !b_valid) begin
          if (b_cnt == 0) b_valid = 1;
          else b_cnt--;
        end

        check("busy", axi_w_isbusy, exp_busy);

        if (r_ready) begin
          ld_strobes++;
          if (exp_ld_q.size() == 0) fail_now("unexpected_r_ready");
          else begin
            rbeat_t e;
            e = exp_ld_q.pop_front();
            check("data_read", data_read, e.data);
            check("resp", resp, e.resp);
          end
        end

        hs_ar = ar_valid && ar_ready;
        hs_r  = r_valid_i && r_ready_o;
        hs_aw = aw_valid && aw_ready;
        hs_w  = w_valid && w_ready;
        hs_b  = b_valid && b_ready;
        store_acc = wvalid;

        if (hs_ar) begin
          if (exp_ar_q.size() == 0) fail_now("unexpected_ar");
          else begin
            addr_t e;
            e = exp_ar_q.pop_front();
            check("ar_addr", ar_addr, e.addr);
            check("ar_size", ar_size, e.size);
            check("ar_len", ar_len, 0);
            check("ar_burst", ar_burst, 1);
            check("ar_id", ar_id, 0);
          end
        end
        if (hs_aw) begin
          if (exp_aw_q.size() == 0) fail_now("unexpected_aw");
          else begin
            addr_t e;
            e = exp_aw_q.pop_front();
            check("aw_addr", aw_addr, e.addr);
            check("aw_size", aw_size, e.size);
            check("aw_len", aw_len, 0);
            check("aw_burst", aw_burst, 1);
            check("aw_id", aw_id, 0);
          end
        end
        if (hs_w) begin
          if (exp_w_q.size() == 0) fail_now("unexpected_w");
          else begin
            wbeat_t e;
            e = exp_w_q.pop_front();
            check("w_data", w_data, e.data);
            check("w_strb", w_strb, e.strb);
            check("w_last", w_last, 1);
          end
        end
        prev_arv = ar_valid; prev_ar_addr = ar_addr;
        prev_awv = aw_valid; prev_aw_addr = aw_addr;
        prev_wv = w_valid;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rvalid = 0;
    wvalid = 0;
    repeat (n) tick();
  endtask

  task automatic do_load(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d,
                         input logic [1:0] rp, input int arw, input int rw,
                         input bit flush, input bit b2b);
    addr_t  ea;
    rbeat_t rb;
    int     n;
    ea.addr = a; ea.size = {1'b0, sz};
    rb.data = d; rb.resp = rp;
    exp_ar_q.push_back(ea);
    slv_r_q.push_back(rb);
    if (!flush) begin
      exp_ld_q.push_back(rb);
      exp_strobes++;
    end
    ar_cnt = arw; r_cnt = rw;
    wvalid = 0; rvalid = 1; raddr = a; rsize = sz;
    if (flush) begin
      n = 0;
      while (!r_ready_o && n < 100) begin tick(); n++; end
      if (!r_ready_o) fail_now("flush_wait_r_ready_o");
      rvalid = 0;
      n = 0;
      while (r_ready_o && n < 100) begin tick(); n++; end
      if (r_ready_o) fail_now("flush_wait_r_beat");
    end else begin
      n = 0;
      do begin tick(); n++; end while (!r_ready && n < 100);
      if (!r_ready) fail_now("load_timeout");
      else check("load_latency", n, (b2b ? 4 : 3) + arw + rw);
    end
  endtask

  task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                          input int aww, input int ww, input int bw, input bit rst_in_b);
    addr_t  ea;
    wbeat_t eb;
    int     n;
    ea.addr = a;
    case ($countones(m))
      8: ea.size = 3;
      4: ea.size = 2;
      2: ea.size = 1;
      1: ea.size = 0;
      default: ea.size = 3;
    endcase
    eb.data = d; eb.strb = m;
    exp_aw_q.push_back(ea);
    exp_w_q.push_back(eb);
    aw_cnt = aww; w_cnt = ww; b_cnt = bw;
    rvalid = 0; wvalid = 1; waddr = a; wdata = d; wmask = m;
    n = 0;
    do begin tick(); wvalid = 0; n++; end while (!b_ready && n < 100);
    if (!b_ready) begin
      fail_now("store_b_ready_timeout");
      return;
    end
    check("b_ready_latency", n, 2 + ((aww > ww) ? aww : ww));
    if (rst_in_b) begin
      reset = 1;
      tick();
      check_zero("rst_in_b");
      reset = 0;
      return;
    end
    n = 0;
    while (axi_w_isbusy && n < 100) begin tick(); n++; end
    if (axi_w_isbusy) fail_now("store_busy_timeout");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ar_valid"}, ar_valid, 0);
    check({tag, "_r_ready_o"}, r_ready_o, 0);
    check({tag, "_aw_valid"}, aw_valid, 0);
    check({tag, "_w_valid"}, w_valid, 0);
    check({tag, "_b_ready"}, b_ready, 0);
    check({tag, "_r_ready"}, r_ready, 0);
    check({tag, "_busy"}, axi_w_isbusy, 0);
    check({tag, "_data_read"}, data_read, 0);
    check({tag, "_resp"}, resp, 0);
    check({tag, "_ar_addr"}, ar_addr, 0);
    check({tag, "_aw_addr"}, aw_addr, 0);
    check({tag, "_w_data"}, w_data, 0);
    check({tag, "_w_strb"}, w_strb, 0);
    check({tag, "_ar_size"}, ar_size, 0);
    check({tag, "_aw_size"}, aw_size, 0);
  endtask

  function automatic logic [7:0] rand_mask();
    int k;
    k = $urandom_range(0, 4);
    case (k)
      0: rand_mask = 8'h01 << $urandom_range(0, 7);
      1: rand_mask = 8'h03 << (2 * $urandom_range(0, 3));
      2: rand_mask = 8'h0F << (4 * $urandom_range(0, 1));
      3: rand_mask = 8'hFF;
      default: rand_mask = 8'($urandom_range(1, 255));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; rvalid = 0; raddr = 0; rsize = 0; wvalid = 0; waddr = 0; wdata = 0; wmask = 0;
    repeat (3) tick();
    check_zero("reset");
    reset = 0;
    idle(2);

    // LD with ready slaves
    do_load(64'h8000_0010, 2'b11, 64'h1122334455667788, 2'b00, 0, 0, 0, 0);
    idle(2);
    // LB with back-pressure: r_ready at cycle 8
    do_load(64'h8000_0003, 2'b00, 64'hA5A5_0000_1234_00FE, 2'b00, 2, 3, 0, 0);
    idle(1);
    // SW with late B
    do_store(64'h8000_0104, 64'hDEADBEEF_00000000, 8'hF0, 0, 0, 5, 0);
    // split AW/W
    do_store(64'h8000_0200, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 3, 0, 0);
    // flushed load
    do_load(64'h8000_0300, 2'b10, 64'hFFFF_0000_FFFF_0000, 2'b00, 0, 2, 1, 0);
    idle(1);
    // back-to-back loads
    do_load(64'h8000_0400, 2'b01, 64'h0000_0000_0000_BEEF, 2'b10, 0, 0, 0, 0);
    do_load(64'h8000_0408, 2'b11, 64'hCAFE_F00D_0000_0001, 2'b00, 0, 0, 0, 1);
    idle(1);
    // reset while waiting for B, then a normal load
    do_store(64'h8000_0500, 64'h1111_2222_3333_4444, 8'h0C, 0, 0, 20, 1);
    idle(1);
    do_load(64'h8000_0600, 2'b11, 64'h5555_6666_7777_8888, 2'b00, 0, 0, 0, 0);
    idle(1);

    // randomized traffic
    begin
      bit last_load;
      last_load = 0;
      for (int i = 0; i < 150; i++) begin
        bit is_load, flush, b2b;
        is_load = ($urandom_range(0, 1) == 1);
        b2b = last_load && is_load && ($urandom_range(0, 1) == 1);
        if (!b2b) idle(last_load ? $urandom_range(1, 3) : $urandom_range(0, 2));
        if (is_load) begin
          flush = ($urandom_range(0, 7) == 0);
          do_load({$urandom, $urandom}, 2'($urandom_range(0, 3)), {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                  $urandom_range(0, 3), $urandom_range(0, 3), flush, b2b);
        end else begin
          do_store({$urandom, $urandom}, {$urandom, $urandom}, rand_mask(),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), 0);
        end
        last_load = is_load;
      end
    end
    idle(6);

    check("strobe_count", ld_strobes, exp_strobes);
    check("ar_q_empty", exp_ar_q.size(), 0);
    check("aw_q_empty", exp_aw_q.size(), 0);
    check("w_q_empty", exp_w_q.size(), 0);
    check("ld_q_empty", exp_ld_q.size(), 0);
    check("slv_r_q_empty", slv_r_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_axi_bridge.md
# dmem_axi_bridge

Data-side AXI4 master bridge that sits directly downstream of `mem_stage`. It receives load requests on `rvalid`/`raddr`/`rsize` and returns load data on the one-cycle `r_ready` strobe. It accepts stores as posted writes on `wvalid`/`waddr`/`wdata`/`wmask` and reports `axi_w_isbusy` until the write response arrives. It handles one transaction at a time, and single beats only (len 0, INCR).

## Interface
- `ADDR_W`, 64: address width on both the core side and the AXI side.
- `DATA_W`, 64: data width; strobe width is `DATA_W/8`.
- `AXI_ID`, 0: constant ID driven on AR/AW.
- clock, in, 1: the single clock.
- reset, in, 1: **synchronous, active-high reset**.
- rvalid, in, 1: load request from `mem_stage`. Held high while the stage is stalled.
- raddr, in, 64: load byte address.
- rsize, in, 2: load size; 00=B, 01=H, 10=W, 11=D.
- r_ready, out, 1: one-cycle load-done strobe. `data_read`/`resp` are valid in the same cycle.
- data_read, out, 64: raw R-channel data. Lanes are not shifted; extraction happens downstream by `raddr[2:0]`.
- resp, out, 2: R-channel response for the completed load.
- wvalid, in, 1: store request; `mem_stage` already gates it with `axi_w_isbusy`.
- waddr, in, 64: store address.
- wdata, in, 64: lane-positioned store data.
- wmask, in, 8: byte strobes.
- axi_w_isbusy, out, 1: a write is outstanding.
- AXI AR channel: ar_valid out 1, ar_ready in 1, ar_addr out 64, ar_size out 3, ar_len out 8, ar_burst out 2, ar_id out 4.
- AXI R channel: r_valid_i in 1, r_ready_o out 1, r_data in 64, r_resp in 2, r_last in 1, r_id in 4.
- AXI AW channel: aw_valid out 1, aw_ready in 1, aw_addr out 64, aw_size out 3, aw_len out 8, aw_burst out 2, aw_id out 4.
- AXI W channel: w_valid out 1, w_ready in 1, w_data out 64, w_strb out 8, w_last out 1.
- AXI B channel: b_valid in 1, b_ready out 1, b_resp in 2, b_id in 4.

## Operation
- FSM states: IDLE, RD_AR, RD_R, RD_DONE, WR_REQ, WR_B. All AXI and core outputs are registered.
- **IDLE, `rvalid`=1:**
  - Latch `raddr` and `{1'b0,rsize}` into `ar_addr` and `ar_size`, then go to RD_AR.
  - If `rvalid` and `wvalid` are both high, the read wins. This case is illegal upstream.
- **RD_AR:**
  - `ar_valid`=1.
  - On `ar_valid & ar_ready`, drop `ar_valid` and go to RD_R.
- **RD_R:**
  - `r_ready_o`=1.
  - On `r_valid_i`, capture `r_data`/`r_resp` into the output registers and go to RD_DONE.
  - `r_last` and `r_id` are ignored.
- **RD_DONE:**
  - `r_ready`=1 for exactly this cycle, and only if `rvalid` is still 1.
  - If `rvalid` has dropped (the request was flushed), the data is discarded and no strobe is issued.
  - Always return to IDLE.
- **IDLE, `wvalid`=1 (the store is accepted this cycle):**
  - Latch `waddr` → `aw_addr`, `wdata` → `w_data`, `wmask` → `w_strb`.
  - Set `aw_size` from the popcount of `wmask`: 8→3, 4→2, 2→1, 1→0. Any other popcount gives 3.
  - Go to WR_REQ.
- **WR_REQ:**
  - `aw_valid` and `w_valid` rise together. Each falls independently on its own handshake.
  - Track completion with an aw_done flag and a w_done flag, including handshakes that happen in the same cycle.
  - When both are done, go to WR_B.
- **WR_B:**
  - `b_ready`=1.
  - On `b_valid`, go to IDLE.
  - `b_resp` is not reported.
- `axi_w_isbusy` = (state ∈ {WR_REQ, WR_B}). It is never asserted during reads.
- Constant fields: `ar_len`/`aw_len`=0, `ar_burst`/`aw_burst`=2'b01, `w_last`=1 whenever `w_valid`, IDs=`AXI_ID`.
- No address decoding is done; all addresses go to AXI.

## Timing
- **Reset (synchronous):**
  - State goes to IDLE.
  - Every output is 0: `ar_valid`, `r_ready_o`, `aw_valid`, `w_valid`, `b_ready`, `r_ready`, `axi_w_isbusy`, `data_read`, `resp`, `ar_addr`, `aw_addr`, `w_data`, `w_strb`, `ar_size`, `aw_size`.
  - Reset mid-transaction abandons the transaction with no strobe.
- **Load latency:** request seen in cycle 0; `ar_valid` in cycle 1; with ready slaves, `r_ready_o` in cycle 2 and `r_ready` in cycle 3. Each slave wait cycle adds one cycle.
- **Back-to-back loads:** the cycle after RD_DONE is IDLE, which samples the next `rvalid`. Minimum spacing is 4 cycles per load.
- **Store acceptance:** zero stall, because `axi_w_isbusy` is low in the accept cycle. `axi_w_isbusy` goes high in cycle 1 and falls in the cycle after the B handshake.
- **Store followed by load:** `mem_stage` holds `rvalid` low while busy, so the load issues only after `b_valid`. This keeps ordering.
- `ar_valid`/`aw_valid`/`w_valid` never drop before their handshake.

## Test plan
- **LD with ready slaves:** ld `raddr`=0x8000_0010, `rsize`=11, slave returns 0x1122334455667788/OKAY → `ar_addr`=0x80000010, `ar_size`=3; `r_ready`=1 in cycle 3 with `data_read`=0x1122334455667788, `resp`=0.
- **LB with back-pressure:** lb `raddr`=0x8000_0003, `ar_ready` delayed 2 cycles, `r_valid` delayed 3 cycles → `ar_size`=0; `r_ready` pulses once at cycle 8; `ar_valid` is stable until its handshake.
- **SW accept and B wait:** `waddr`=0x8000_0104, `wmask`=0xF0, `wdata`=0xDEADBEEF_00000000 → `aw_size`=2, `w_strb`=0xF0; `axi_w_isbusy` is 1 from cycle 1 until the cycle after `b_valid`, which is asserted 5 cycles late.
- **Split AW/W:** `aw_ready` at cycle 1 and `w_ready` at cycle 4 → `aw_valid` falls after cycle 1, `w_valid` after cycle 4; `b_ready` rises at cycle 5.
- **Flushed load:** `rvalid` drops while in RD_R → R beat consumed, no `r_ready` pulse, state returns to IDLE.
- **Reset in WR_B:** reset asserted → next cycle all outputs are 0, `axi_w_isbusy`=0, and a new load is accepted normally.
